// File: rtl/rmii_game_tx.sv
// rmii_game_tx: sends one fixed-layout game-state Ethernet frame per accepted request over RMII.
// Defining RMII_TX_FCS_EN adds the CRC-32 engine and the 4-byte FCS state.
module rmii_game_tx #(
   parameter logic [47:0] DEST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
   input  logic        eth_clk,
   input  logic        eth_rstn,
   input  logic        tx_valid_in,
   output logic        tx_ready_out,
   input  logic [10:0] player_x,
   input  logic [10:0] player_y,
   input  logic [8:0]  direction,
   input  logic [2:0]  game_stat,
   input  logic        reset_req,
   output logic        eth_txen,
   output logic [1:0]  eth_txd,
   output logic        tx_done_out
);
   localparam logic [111:0] HEADER = {DEST_MAC, SRC_MAC, ETHERTYPE};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_PAYLOAD,
      S_PAD,
`ifdef RMII_TX_FCS_EN
      S_FCS,
`endif
      S_IFG
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt, cnt_last;
   logic        at_last;
   logic        accept;
   logic        ready_q;
   logic [47:0] payload;
   logic [7:0]  cur_byte;
   logic [1:0]  dibit;

   // Handshake: a request transfers on a clock edge where tx_valid_in and
   // tx_ready_out are both 1; tx_valid_in seen while tx_ready_out is 0 is dropped.
   assign accept  = tx_valid_in && ready_q;
   assign at_last = (cnt == cnt_last);

   always_comb begin
      cnt_last = 8'd0;
      case (state)
         S_PREAMBLE: cnt_last = 8'd31;
         S_HEADER:   cnt_last = 8'd55;
         S_PAYLOAD:  cnt_last = 8'd23;
         S_PAD:      cnt_last = 8'd159;
`ifdef RMII_TX_FCS_EN
         S_FCS:      cnt_last = 8'd15;
`endif
         S_IFG:      cnt_last = 8'd47;
         default:    cnt_last = 8'd0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 8'd1;
      if (state == S_IDLE || at_last)
         cnt_nxt = 8'd0;
      case (state)
         S_IDLE:     if (accept)  state_nxt = S_PREAMBLE;
         S_PREAMBLE: if (at_last) state_nxt = S_HEADER;
         S_HEADER:   if (at_last) state_nxt = S_PAYLOAD;
         S_PAYLOAD:  if (at_last) state_nxt = S_PAD;
`ifdef RMII_TX_FCS_EN
         S_PAD:      if (at_last) state_nxt = S_FCS;
         S_FCS:      if (at_last) state_nxt = S_IFG;
`else
         S_PAD:      if (at_last) state_nxt = S_IFG;
`endif
         S_IFG:      if (at_last) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge eth_clk) begin
      if (!eth_rstn) begin
         state   <= S_IDLE;
         cnt     <= 8'd0;
         ready_q <= 1'b0;
         payload <= 48'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= (state_nxt == S_IDLE);
         if (accept)
            payload <= {player_x, 1'b0, player_y, 1'b0, direction, 3'b000,
                        game_stat, 1'b0, reset_req, 7'b0000000};
      end
   end

`ifdef RMII_TX_FCS_EN
   logic [31:0] crc;
   logic [31:0] fcs;

   // Reflected CRC-32, advanced by one dibit (bit 0 first) per transmitted cycle.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign fcs = ~crc;

   always_ff @(posedge eth_clk) begin
      if (!eth_rstn)
         crc <= 32'hFFFF_FFFF;
      else if (state == S_IDLE)
         crc <= 32'hFFFF_FFFF;
      else if (state == S_HEADER || state == S_PAYLOAD || state == S_PAD)
         crc <= crc_step(crc, dibit);
   end
`endif

   // Bytes go out in order, each as four dibits starting from bits [1:0].
   always_comb begin
      cur_byte = 8'h00;
      case (state)
         S_PREAMBLE: cur_byte = (cnt[4:2] == 3'd7) ? 8'hD5 : 8'h55;
         S_HEADER:   cur_byte = HEADER[{4'd13 - cnt[5:2], 3'b000} +: 8];
         S_PAYLOAD:  cur_byte = payload[{3'd5 - cnt[4:2], 3'b000} +: 8];
         default:    cur_byte = 8'h00;
      endcase
      dibit = cur_byte[{cnt[1:0], 1'b0} +: 2];
`ifdef RMII_TX_FCS_EN
      if (state == S_FCS)
         dibit = fcs[{cnt[3:0], 1'b0} +: 2];
`endif
   end

   assign eth_txen     = (state != S_IDLE) && (state != S_IFG);
   assign eth_txd      = eth_txen ? dibit : 2'b00;
   assign tx_ready_out = ready_q;
   assign tx_done_out  = (state == S_IFG) && at_last;

endmodule

// File: tb/tb_rmii_game_tx.sv
// tb_rmii_game_tx: scoreboard bench for rmii_game_tx; expected dibit streams come from a byte-level frame model.
// Works for builds with or without RMII_TX_FCS_EN.
module tb_rmii_game_tx;
   localparam logic [47:0] DEST  = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;
   localparam logic [15:0] ETYPE = 16'h88B5;
`ifdef RMII_TX_FCS_EN
   localparam int FRAME_BYTES = 72;
`else
   localparam int FRAME_BYTES = 68;
`endif

   logic        eth_clk;
   logic        eth_rstn;
   logic        tx_valid_in;
   logic        tx_ready_out;
   logic [10:0] player_x;
   logic [10:0] player_y;
   logic [8:0]  direction;
   logic [2:0]  game_stat;
   logic        reset_req;
   logic        eth_txen;
   logic [1:0]  eth_txd;
   logic        tx_done_out;

   rmii_game_tx #(
      .DEST_MAC  (DEST),
      .SRC_MAC   (SRC),
      .ETHERTYPE (ETYPE)
   ) dut (
      .eth_clk      (eth_clk),
      .eth_rstn     (eth_rstn),
      .tx_valid_in  (tx_valid_in),
      .tx_ready_out (tx_ready_out),
      .player_x     (player_x),
      .player_y     (player_y),
      .direction    (direction),
      .game_stat    (game_stat),
      .reset_req    (reset_req),
      .eth_txen     (eth_txen),
      .eth_txd      (eth_txd),
      .tx_done_out  (tx_done_out)
   );

   // ---------------- clock ----------------
   initial eth_clk = 1'b0;
   always #10 eth_clk = ~eth_clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [1:0] exp_q[$];
   int         len_q[$];
   logic [1:0] act_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int rise_cnt = 0;
   int done_cnt = 0;
   int gap_check_idx = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
         else             c = c >> 1;
      end
      return c;
   endfunction

   // CRC over everything after the SFD, FCS included, bit-reversed to the usual residue form.
   function automatic logic [31:0] residue(input logic [1:0] d[$]);
      logic [31:0] c;
      logic [31:0] r;
      logic [7:0]  b;
      c = 32'hFFFF_FFFF;
      for (int j = 8; j < FRAME_BYTES; j++) begin
         b = {d[4*j+3], d[4*j+2], d[4*j+1], d[4*j]};
         c = crc_byte(c, b);
      end
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return r;
   endfunction

   // Reference model: build the frame as bytes, then expand to dibits low pair first.
   task automatic model_push(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                             input logic [2:0] gs, input logic rr);
      logic [7:0]   fb[$];
      logic [47:0]  w;
      logic [111:0] hdr;
      for (int i = 0; i < 7; i++) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      hdr = {DEST, SRC, ETYPE};
      for (int i = 0; i < 14; i++) fb.push_back(hdr[111-8*i -: 8]);
      w = (48'(x) << 37) | (48'(y) << 25) | (48'(d) << 15) | (48'(gs) << 9) | (48'(rr) << 7);
      for (int i = 0; i < 6; i++) fb.push_back(w[47-8*i -: 8]);
      for (int i = 0; i < 40; i++) fb.push_back(8'h00);
`ifdef RMII_TX_FCS_EN
      begin
         logic [31:0] c;
         c = 32'hFFFF_FFFF;
         for (int i = 8; i < 68; i++) c = crc_byte(c, fb[i]);
         c = ~c;
         for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
      end
`endif
      foreach (fb[i])
         for (int k = 0; k < 4; k++) exp_q.push_back(fb[i][2*k +: 2]);
      len_q.push_back(fb.size() * 4);
   endtask

   // ---------------- monitor ----------------
   initial begin
      bit in_frame;
      int burst_len;
      int cur_len;
      int low_cnt;
      in_frame  = 0;
      burst_len = 0;
      cur_len   = -1;
      low_cnt   = 1000;
      forever begin
         @(negedge eth_clk);
         if (!eth_rstn) begin
            in_frame = 0;
            low_cnt  = 1000;
            act_q.delete();
         end else begin
            if (eth_txen) begin
               if (!in_frame) begin
                  in_frame  = 1;
                  burst_len = 0;
                  act_q.delete();
                  rise_cnt++;
                  if (rise_cnt == gap_check_idx) check("b2b_gap", low_cnt, 49);
                  low_cnt = 1000;
                  if (len_q.size() == 0) begin
                     check("unexpected_frame", 1, 0);
                     cur_len = -1;
                  end else begin
                     cur_len = len_q.pop_front();
                  end
               end
               burst_len++;
               act_q.push_back(eth_txd);
               if (cur_len >= 0 && burst_len <= cur_len && exp_q.size() > 0)
                  check("dibit", eth_txd, exp_q.pop_front());
            end else begin
               check("txd_idle", eth_txd, 2'b00);
               if (in_frame) begin
                  in_frame = 0;
                  if (cur_len >= 0) begin
                     check("burst_len", burst_len, cur_len);
                     for (int i = burst_len; i < cur_len; i++)
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                  end
`ifdef RMII_TX_FCS_EN
                  if (burst_len == 288) check("fcs_residue", residue(act_q), 32'hC704DD7B);
`endif
                  low_cnt = 0;
               end
               if (low_cnt < 1000) low_cnt++;
            end
            if (tx_done_out) done_cnt++;
            if (tx_done_out || low_cnt == 48) check("done_timing", tx_done_out, low_cnt == 48);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_pulse(input int ncyc);
      eth_rstn    = 1'b0;
      tx_valid_in = 1'b0;
      exp_q.delete();
      len_q.delete();
      repeat (ncyc) begin
         @(posedge eth_clk);
         @(negedge eth_clk);
         check("rst_txen", eth_txen, 0);
         check("rst_txd", eth_txd, 0);
         check("rst_ready", tx_ready_out, 0);
         check("rst_done", tx_done_out, 0);
      end
      eth_rstn = 1'b1;
      @(posedge eth_clk);
      @(negedge eth_clk);
      check("ready_after_release", tx_ready_out, 1);
   endtask

   task automatic scramble_inputs();
      player_x  = 11'($urandom_range(0, 2047));
      player_y  = 11'($urandom_range(0, 2047));
      direction = 9'($urandom_range(0, 359));
      game_stat = 3'($urandom_range(0, 7));
      reset_req = 1'($urandom_range(0, 1));
   endtask

   task automatic send_frame(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                             input logic [2:0] gs, input logic rr);
      int n;
      n = 0;
      @(negedge eth_clk);
      while (!tx_ready_out && n < 2000) begin
         @(negedge eth_clk);
         n++;
      end
      check("ready_before_send", tx_ready_out, 1);
      player_x    = x;
      player_y    = y;
      direction   = d;
      game_stat   = gs;
      reset_req   = rr;
      tx_valid_in = 1'b1;
      model_push(x, y, d, gs, rr);
      @(posedge eth_clk);
      #1;
      tx_valid_in = 1'b0;
      scramble_inputs();
      @(negedge eth_clk);
      check("first_txen", eth_txen, 1);
      check("first_txd", eth_txd, 2'b01);
   endtask

   task automatic send_random();
      send_frame(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                 9'($urandom_range(0, 359)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!tx_done_out && n < limit) begin
         @(negedge eth_clk);
         n++;
      end
      check("done_seen", tx_done_out, 1);
      @(negedge eth_clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hs;
      int n;
      int d0;
      eth_rstn    = 1'b0;
      tx_valid_in = 1'b0;
      player_x    = '0;
      player_y    = '0;
      direction   = '0;
      game_stat   = '0;
      reset_req   = 1'b0;

      reset_pulse(3);

      send_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
      wait_done(1000);
      send_frame(11'd2047, 11'd2047, 9'd359, 3'd7, 1'b1);
      wait_done(1000);
      send_frame(11'd0, 11'd0, 9'd0, 3'd0, 1'b0);
      wait_done(1000);
      for (int i = 0; i < 6; i++) begin
         send_random();
         wait_done(1000);
      end

      // Request while busy must be dropped.
      send_random();
      d0 = done_cnt;
      repeat (49) @(negedge eth_clk);
      check("busy_ready", tx_ready_out, 0);
      scramble_inputs();
      tx_valid_in = 1'b1;
      @(posedge eth_clk);
      #1;
      tx_valid_in = 1'b0;
      wait_done(1000);
      repeat (60) @(negedge eth_clk);
      check("busy_done_once", done_cnt - d0, 1);

      // Reset sampled at the edge ending dibit 100.
      send_random();
      repeat (99) @(posedge eth_clk);
      #1;
      reset_pulse(2);
      send_random();
      wait_done(1000);

      // Back-to-back with tx_valid_in held high and fields unchanged.
      @(negedge eth_clk);
      scramble_inputs();
      model_push(player_x, player_y, direction, game_stat, reset_req);
      model_push(player_x, player_y, direction, game_stat, reset_req);
      gap_check_idx = rise_cnt + 2;
      tx_valid_in = 1'b1;
      hs = 0;
      n  = 0;
      while (hs < 2 && n < 2000) begin
         if (tx_ready_out) hs++;
         @(posedge eth_clk);
         #1;
         if (hs == 2) tx_valid_in = 1'b0;
         @(negedge eth_clk);
         n++;
      end
      tx_valid_in = 1'b0;
      check("b2b_accepts", hs, 2);
      wait_done(1000);

      repeat (20) @(negedge eth_clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("len_q_empty", len_q.size(), 0);
      check("b2b_gap_seen", rise_cnt >= gap_check_idx, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
